// File: rtl/wb_line_fill.sv
// Wishbone cache-line filler: issues WORDS pipelined reads for one line and
// assembles the tagged acks (any order) into line_o, then pulses done_o.
//
// state | meaning
// IDLE  | waiting for req_i; line_o keeps the last filled line
// ISSUE | strobing word addresses, one per accepted (non-stalled) cycle
// DRAIN | all words requested, collecting outstanding acks
// DONE  | line complete, done_o high for this single cycle
module wb_line_fill #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int LINE_LOG2  = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     req_i,
  input  logic [ADDR_WIDTH-LINE_LOG2-1:0]          req_line_i,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic [DATA_WIDTH*(2**LINE_LOG2)-1:0]     line_o,
  output logic                                     cyc_o,
  output logic                                     stb_o,
  output logic                                     we_o,
  output logic [ADDR_WIDTH-1:0]                    adr_o,
  output logic [DATA_WIDTH-1:0]                    dat_o,
  input  logic [DATA_WIDTH-1:0]                    dat_i,
  input  logic [ADDR_WIDTH-1:0]                    tag_i,
  input  logic                                     ack_i,
  input  logic                                     stall_i
);

  localparam int WORDS = 2**LINE_LOG2;
  localparam int LW    = ADDR_WIDTH - LINE_LOG2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                      state_q, state_d;
  logic [LW-1:0]               line_addr_q, line_addr_d;
  logic [LINE_LOG2-1:0]        cnt_q, cnt_d;
  logic [WORDS-1:0]            mask_q, mask_d;
  logic [DATA_WIDTH*WORDS-1:0] line_q, line_d;
  logic                        busy_q, done_q, cyc_q, stb_q;

  logic                        accept;
  logic                        ack_hit;
  logic [LINE_LOG2-1:0]        tag_word;

  // stb_q is only ever high in ISSUE, so it doubles as the issue qualifier
  assign accept   = stb_q && !stall_i;
  assign tag_word = tag_i[LINE_LOG2-1:0];
  assign ack_hit  = ack_i && (state_q == ISSUE || state_q == DRAIN) &&
                    (tag_i[ADDR_WIDTH-1:LINE_LOG2] == line_addr_q);

  // Next-state, ack capture and issue counter update
  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    line_d      = line_q;

    if (ack_hit) begin
      line_d[int'(tag_word)*DATA_WIDTH +: DATA_WIDTH] = dat_i;
      mask_d[tag_word] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (req_i) begin
          line_addr_d = req_line_i;
          cnt_d       = '0;
          mask_d      = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          // counter parks on the last word; it is only rewound by a new request
          if (cnt_q == {LINE_LOG2{1'b1}}) begin
            state_d = (&mask_d) ? DONE : DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (&mask_d) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; flags are computed from the next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      cnt_q       <= '0;
      mask_q      <= '0;
      line_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      line_q      <= line_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      cyc_q       <= (state_d == ISSUE) || (state_d == DRAIN);
      stb_q       <= (state_d == ISSUE);
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign line_o = line_q;
  assign cyc_o  = cyc_q;
  assign stb_o  = stb_q;
  assign we_o   = 1'b0;
  assign dat_o  = '0;
  assign adr_o  = {line_addr_q, cnt_q};

endmodule
